apb_master: RTL



---
 rtl/apb_master.sv | 125 ++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// APB3 requester: turns a valid/ready command into a SETUP/ACCESS transfer and
// returns one response pulse per command, with a wait-state timeout guard.
module apb_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int unsigned CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CNT_W-1:0]        wait_cnt;
    logic [CNT_W-1:0]        wait_cnt_d;
    logic                    accept_c;
    logic                    timeout_hit_c;
    logic                    psel_d;
    logic                    penable_d;
    logic                    rsp_valid_d;
    logic                    rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_d;

    assign cmd_ready     = (state == IDLE);
    assign accept_c      = cmd_valid && (state == IDLE);
    // The edge that ends the TIMEOUT-th stalled ACCESS cycle aborts the transfer.
    assign timeout_hit_c = (TIMEOUT != 0) && (state == ACCESS) && !pready
                           && (wait_cnt == CNT_W'(TO_LAST));

    // State register
    always_ff @(posedge pclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (cmd_valid) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (pready || timeout_hit_c) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: next values for the registered APB strobes, response and counter
    always_comb begin
        psel_d      = (next_state != IDLE);
        penable_d   = (next_state == ACCESS);
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        wait_cnt_d  = wait_cnt;
        if (state == ACCESS && pready) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = pslverr;
            rsp_rdata_d = pwrite ? '0 : prdata;
        end else if (timeout_hit_c) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
        end
        if (next_state == SETUP) begin
            wait_cnt_d = '0;
        end else if (state == ACCESS && !pready && TIMEOUT != 0) begin
            wait_cnt_d = wait_cnt + CNT_W'(1);
        end
    end

    // Registered outputs; address/data/direction hold until the next accept
    always_ff @(posedge pclk) begin
        if (reset) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            wait_cnt  <= '0;
        end else begin
            psel      <= psel_d;
            penable   <= penable_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            wait_cnt  <= wait_cnt_d;
            if (accept_c) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_write ? cmd_wdata : '0;
            end
        end
    end

endmodule
